eth_rx_frame_filter: RTL and testbench
======================================

# eth_rx_frame_filter

Receive-side destination-address filter placed directly downstream of the Ethernet top-level RX stream output (64-bit AXI Stream after the 8→64 upsizer) and upstream of the RX DMA. Inspects the destination MAC in the first beat of each frame and forwards or silently drops the whole frame according to a runtime-configured policy. It optionally keeps accepted/dropped frame counters. It adds one registered pipeline stage at full throughput.

## Interface
- `axi_stream_req_t`, `eth_top_pkg::s_req_t`: AXIS request struct (tvalid, t.data/strb/keep/last/id/dest/user).
- `axi_stream_rsp_t`, `eth_top_pkg::s_rsp_t`: AXIS response struct (tready).
- `DataWidth`, 64: tdata width. Must be ≥ 48; only 64 is supported.
- `CntWidth`, 32: statistics counter width.

- `clk_i`  in  1  the single clock, rising edge (125 MHz domain). One clock only.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `rx_axis_req_i`  in  struct  frames from the Ethernet top RX output.
- `rx_axis_rsp_o`  out  struct  tready toward upstream.
- `rx_axis_req_o`  out  struct  filtered frames to the DMA.
- `rx_axis_rsp_i`  in  struct  tready from downstream.
- `mac_addr_i`  in  48  station address; `[7:0]` is the first wire byte.
- `promisc_i`  in  1  accept all frames.
- `bcast_en_i`  in  1  accept ff:ff:ff:ff:ff:ff.
- `mcast_en_i`  in  1  accept group addresses (first byte bit 0 = 1).
- `frames_ok_o`  out  CntWidth  accepted-frame count (stats build only).
- `frames_drop_o`  out  CntWidth  dropped-frame count (stats build only).

## Operation
- Byte lane k = `tdata[8k+7:8k]`. Lane 0 is first on the wire. Destination MAC = lanes 0..5 of the first beat.
- FSM states:
  - IDLE: waiting for a first beat.
  - PASS: forwarding the current frame.
  - DROP: discarding the current frame.
- Decision on the first-beat handshake (input valid && ready_o in IDLE), evaluated in this priority order:
  1. Runt: tlast=1 and `keep[5:0]` != 6'h3F → drop.
  2. `promisc_i` → accept.
  3. DA == all ones → accept iff `bcast_en_i`.
  4. DA lane0 bit0 = 1 → accept iff `mcast_en_i`.
  5. DA == `mac_addr_i` → accept.
  6. Otherwise drop.
- Accept on a beat with tlast → remain in IDLE. Otherwise → PASS. Drop with tlast → IDLE. Otherwise → DROP.
- PASS: every beat is forwarded unchanged (all struct fields). The tlast handshake → IDLE.
- DROP: every beat is consumed with `rx_axis_rsp_o.tready`=1 and not forwarded. The tlast handshake → IDLE.
- Config inputs are sampled only at the decision point. Changes mid-frame do not affect the current frame.
- tkeep/tstrb are never altered. Frames are never truncated or merged.

## Timing
- Output is a single pipeline register (valid + payload).
- `tready_o = !out_valid || rx_axis_rsp_i.tready` in IDLE/PASS. It is 1 in DROP.
- Latency: 1 cycle from input handshake to output valid. Throughput: 1 beat/cycle.
- Output payload is held stable while valid && !ready (AXIS rule).
- Back-to-back frames: the first beat of frame N+1 may be accepted in the cycle after the tlast of frame N. A one-beat frame directly after a one-beat frame is legal.
- Reset values:
  - `rx_axis_req_o.tvalid`=0, payload 0.
  - `rx_axis_rsp_o.tready`=0 while `rst_ni`=0.
  - FSM = IDLE.
  - Counters = 0.
- Reset asserted mid-frame: the partial frame is abandoned. The next incoming beat is treated as a first beat. Upstream is responsible for framing.

## Configuration
- `ETH_RX_FILTER_STATS_EN` defined:
  - Counters are implemented.
  - `frames_ok_o` increments on the output-side tlast handshake.
  - `frames_drop_o` increments on the tlast handshake of a dropped frame.
  - Both saturate at 2^CntWidth−1.
  - Both events in the same cycle increment both counters.
- Undefined: no counter flops; both outputs are tied to 0.

## Structure
- Shared package `eth_rx_filter_pkg`:
  - `filt_state_e` (IDLE/PASS/DROP).
  - `MacBcast` = 48'hFFFF_FFFF_FFFF.
  - `MacLenBytes` = 6.
- One natural sub-module: `eth_rx_filter_decide`, the combinational first-beat classifier (DA, runt, policy → accept). FSM, output register and counters stay in the top.

## Test plan
- DA = `mac_addr_i` = 02:00:00:00:00:01, 8-beat frame, all other enables 0 → 8 beats out, one cycle later, identical data; frames_ok=1.
- DA = 02:00:00:00:00:02, promisc=0 → 0 beats out; input fully consumed with tready=1; frames_drop=1.
- Broadcast DA, 3 beats, with `bcast_en_i`=0 then =1 → first frame dropped, second forwarded. Repeat with multicast DA 01:00:5e:00:00:01 and `mcast_en_i`.
- Runt: single beat, tlast=1, keep=8'h0F, `promisc_i`=1 → dropped, frames_drop increments.
- Downstream tready toggling 1/0 every cycle, 16 back-to-back matching frames of 1–9 beats → all beats delivered in order, no beat duplicated or lost, payload stable while stalled.
- `rst_ni` pulsed low during beat 3 of a 6-beat frame → outputs 0 immediately; after release, a new matching frame passes intact; counters read 0 plus the new frame.

Source files
------------

// File: rtl/eth_rx_filter_pkg.sv
// Shared types and constants for the Ethernet RX destination-address filter.
// The optional statistics counters are enabled by defining ETH_RX_FILTER_STATS_EN.
package eth_rx_filter_pkg;

  localparam int DataWidth   = 64;
  localparam int StrbWidth   = DataWidth / 8;
  localparam int IdWidth     = 4;
  localparam int DestWidth   = 4;
  localparam int UserWidth   = 8;
  localparam int CntWidth    = 32;
  localparam int MacLenBytes = 6;

  localparam logic [8*MacLenBytes-1:0] MacBcast = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } filt_state_e;

  // AXIS payload; everything except tvalid/tready travels through the filter untouched.
  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic [StrbWidth-1:0] keep;
    logic                 last;
    logic [IdWidth-1:0]   id;
    logic [DestWidth-1:0] dest;
    logic [UserWidth-1:0] user;
  } axis_t;

  typedef struct packed {
    logic  tvalid;
    axis_t t;
  } axi_stream_req_t;

  typedef struct packed {
    logic tready;
  } axi_stream_rsp_t;

endpackage

// File: rtl/eth_rx_filter_decide.sv
// Combinational first-beat classifier: turns the destination MAC, runt status
// and the current policy inputs into a single accept/drop decision.
module eth_rx_filter_decide
  import eth_rx_filter_pkg::*;
(
  input  logic [8*MacLenBytes-1:0] da_i,
  input  logic [MacLenBytes-1:0]   keep_i,
  input  logic                     last_i,
  input  logic [8*MacLenBytes-1:0] mac_addr_i,
  input  logic                     promisc_i,
  input  logic                     bcast_en_i,
  input  logic                     mcast_en_i,
  output logic                     accept_o
);

  // A one-beat frame that does not even carry a full destination address.
  logic runt;
  assign runt = last_i && (keep_i != {MacLenBytes{1'b1}});

  // Priority chain: runt beats everything, promiscuous beats the address rules.
  always_comb begin
    accept_o = 1'b0;
    if (runt) begin
      accept_o = 1'b0;
    end else if (promisc_i) begin
      accept_o = 1'b1;
    end else if (da_i == MacBcast) begin
      accept_o = bcast_en_i;
    end else if (da_i[0]) begin
      accept_o = mcast_en_i;
    end else if (da_i == mac_addr_i) begin
      accept_o = 1'b1;
    end
  end

endmodule

// File: rtl/eth_rx_frame_filter.sv
// Ethernet RX destination-address filter with one registered output stage.
// Define ETH_RX_FILTER_STATS_EN to build the accepted/dropped frame counters.
//
// Handshake: a beat transfers on a rising edge where tvalid && tready. The
// output register presents a beat until downstream takes it (payload stable
// while valid && !ready). Upstream tready is !out_valid || downstream tready
// while forwarding or idle, and constant 1 while discarding a frame.
module eth_rx_frame_filter
  import eth_rx_filter_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  axi_stream_req_t     rx_axis_req_i,
  output axi_stream_rsp_t     rx_axis_rsp_o,
  output axi_stream_req_t     rx_axis_req_o,
  input  axi_stream_rsp_t     rx_axis_rsp_i,
  input  logic [47:0]         mac_addr_i,
  input  logic                promisc_i,
  input  logic                bcast_en_i,
  input  logic                mcast_en_i,
  output logic [CntWidth-1:0] frames_ok_o,
  output logic [CntWidth-1:0] frames_drop_o,
  output filt_state_e         dbg_state_o
);

  filt_state_e state_q, state_d;
  logic        out_valid_q;
  axis_t       out_data_q;
  logic        in_ready;
  logic        in_hs;
  logic        accept;
  logic        fwd;

  eth_rx_filter_decide u_decide (
    .da_i       (rx_axis_req_i.t.data[8*MacLenBytes-1:0]),
    .keep_i     (rx_axis_req_i.t.keep[MacLenBytes-1:0]),
    .last_i     (rx_axis_req_i.t.last),
    .mac_addr_i (mac_addr_i),
    .promisc_i  (promisc_i),
    .bcast_en_i (bcast_en_i),
    .mcast_en_i (mcast_en_i),
    .accept_o   (accept)
  );

  assign in_hs = rx_axis_req_i.tvalid && in_ready;
  // A beat enters the output register on an accepted first beat or any beat of a passing frame.
  assign fwd   = in_hs && (((state_q == IDLE) && accept) || (state_q == PASS));

  // State register; reset abandons any partial frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: decide on the first beat, return to IDLE on every tlast handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_hs && !rx_axis_req_i.t.last) begin
          state_d = accept ? PASS : DROP;
        end
      end
      PASS, DROP: begin
        if (in_hs && rx_axis_req_i.t.last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: upstream ready, forced low while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE, PASS: in_ready = rst_ni && (!out_valid_q || rx_axis_rsp_i.tready);
      DROP:       in_ready = rst_ni;
      default:    in_ready = 1'b0;
    endcase
  end

  // Output pipeline register: load on forward, empty when downstream takes the beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (fwd) begin
      out_valid_q <= 1'b1;
      out_data_q  <= rx_axis_req_i.t;
    end else if (rx_axis_rsp_i.tready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign rx_axis_req_o.tvalid = out_valid_q;
  assign rx_axis_req_o.t      = out_data_q;
  assign rx_axis_rsp_o.tready = in_ready;
  assign dbg_state_o          = state_q;

`ifdef ETH_RX_FILTER_STATS_EN
  logic                ok_evt;
  logic                drop_evt;
  logic [CntWidth-1:0] ok_q;
  logic [CntWidth-1:0] drop_q;

  assign ok_evt   = out_valid_q && rx_axis_rsp_i.tready && out_data_q.last;
  assign drop_evt = in_hs && rx_axis_req_i.t.last &&
                    (((state_q == IDLE) && !accept) || (state_q == DROP));

  // Saturating frame counters; both may step in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ok_q   <= '0;
      drop_q <= '0;
    end else begin
      if (ok_evt && (ok_q != '1)) begin
        ok_q <= ok_q + 1'b1;
      end
      if (drop_evt && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign frames_ok_o   = ok_q;
  assign frames_drop_o = drop_q;
`else
  assign frames_ok_o   = '0;
  assign frames_drop_o = '0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Self-checking bench for eth_rx_frame_filter: directed and randomized frames,
// frame-level acceptance model, expected-beat queue and output monitor.
module tb_eth_rx_frame_filter;
  import eth_rx_filter_pkg::*;

`ifdef ETH_RX_FILTER_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  localparam logic [47:0] MacOwn   = 48'h01_00_00_00_00_02; // 02:00:00:00:00:01
  localparam logic [47:0] MacOther = 48'h02_00_00_00_00_02; // 02:00:00:00:00:02
  localparam logic [47:0] MacMcast = 48'h01_00_00_5e_00_01; // 01:00:5e:00:00:01

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni;
  always #4 clk = ~clk;

  axi_stream_req_t     req_i, req_o;
  axi_stream_rsp_t     rsp_o, rsp_i;
  logic [47:0]         mac_addr;
  logic                promisc, bcast_en, mcast_en;
  logic [CntWidth-1:0] frames_ok, frames_drop;
  filt_state_e         dbg_state;

  eth_rx_frame_filter dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .rx_axis_req_i (req_i),
    .rx_axis_rsp_o (rsp_o),
    .rx_axis_req_o (req_o),
    .rx_axis_rsp_i (rsp_i),
    .mac_addr_i    (mac_addr),
    .promisc_i     (promisc),
    .bcast_en_i    (bcast_en),
    .mcast_en_i    (mcast_en),
    .frames_ok_o   (frames_ok),
    .frames_drop_o (frames_drop),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [$bits(axis_t)-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int exp_ok   = 0;
  int exp_drop = 0;
  int ds_mode  = 0; // 0: always ready, 1: toggle, 2: random

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
    return Stats ? 32'(v) : 32'd0;
  endfunction

  // Frame-level acceptance rules, byte by byte on the destination address.
  function automatic bit model_accept(input logic [47:0] da, input logic [7:0] keep, input bit last,
                                      input logic [47:0] mac, input bit pr, input bit bc, input bit mc);
    bit all_ff = 1'b1;
    bit own    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (da[8*i +: 8] != 8'hff)         all_ff = 1'b0;
      if (da[8*i +: 8] != mac[8*i +: 8]) own    = 1'b0;
    end
    if (last) begin
      for (int i = 0; i < 6; i++) if (!keep[i]) return 1'b0;
    end
    if (pr)     return 1'b1;
    if (all_ff) return bc;
    if (da[0])  return mc;
    return own;
  endfunction

  // ---------------- downstream ready driver ----------------
  initial begin
    rsp_i.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ds_mode)
        0:       rsp_i.tready = 1'b1;
        1:       rsp_i.tready = ~rsp_i.tready;
        default: rsp_i.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- output monitor ----------------
  bit    stall_prev = 1'b0;
  axis_t held;
  always @(negedge clk) begin
    if (!rst_ni) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("stable_while_stalled", {req_o.tvalid, req_o.t}, {1'b1, held});
      if (req_o.tvalid && rsp_i.tready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", req_o.t, '0 - 1);
        else chk("out_beat", req_o.t, exp_q.pop_front());
      end
      stall_prev = req_o.tvalid && !rsp_i.tready;
      held       = req_o.t;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input axis_t b, input bit drop_chk);
    bit hs    = 1'b0;
    int tries = 0;
    req_i.t      = b;
    req_i.tvalid = 1'b1;
    while (!hs && tries < 500) begin
      @(negedge clk);
      hs = rsp_o.tready;
      if (drop_chk && tries == 0) chk("drop_tready", rsp_o.tready, 1);
      @(posedge clk);
      #1;
      tries++;
    end
    if (!hs) chk("handshake_timeout", 0, 1);
  endtask

  function automatic axis_t make_beat(input logic [47:0] da, input int k, input int nb, input logic [7:0] lk);
    axis_t b;
    b.data = {$urandom(), $urandom()};
    if (k == 0) b.data[47:0] = da;
    b.keep = (k == nb - 1) ? lk : 8'hff;
    b.strb = b.keep;
    b.last = (k == nb - 1);
    b.id   = 4'($urandom());
    b.dest = 4'($urandom());
    b.user = 8'($urandom());
    return b;
  endfunction

  task automatic send_frame(input logic [47:0] da, input int nb, input logic [7:0] lk,
                            input int gap_max, input bit chk_lat, input bit scramble);
    axis_t b;
    bit    acc;
    int    n;
    acc = model_accept(da, (nb == 1) ? lk : 8'hff, nb == 1, mac_addr, promisc, bcast_en, mcast_en);
    if (acc) exp_ok++; else exp_drop++;
    for (int k = 0; k < nb; k++) begin
      b = make_beat(da, k, nb, lk);
      if (acc) exp_q.push_back(b);
      if (gap_max > 0) begin
        n = $urandom_range(0, gap_max);
        if (n > 0) begin
          req_i.tvalid = 1'b0;
          repeat (n) begin @(posedge clk); #1; end
        end
      end
      drive_beat(b, !acc && k > 0);
      if (chk_lat && acc) chk("latency_one_cycle", {req_o.tvalid, req_o.t}, {1'b1, b});
      if (scramble && k == 0) begin
        promisc  = 1'($urandom_range(0, 1));
        bcast_en = 1'($urandom_range(0, 1));
        mcast_en = 1'($urandom_range(0, 1));
      end
    end
    req_i.tvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || req_o.tvalid) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_frames_ok"}, frames_ok, cnt_exp(exp_ok));
    chk({tag, "_frames_drop"}, frames_drop, cnt_exp(exp_drop));
  endtask

  // ---------------- directed + random sequence ----------------
  logic [7:0]  lk_tab [7] = '{8'hff, 8'h7f, 8'h3f, 8'h1f, 8'h0f, 8'h03, 8'h01};
  logic [47:0] da;
  axis_t       b;

  initial begin
    rst_ni   = 1'b0;
    req_i    = '0;
    mac_addr = MacOwn;
    promisc  = 1'b0;
    bcast_en = 1'b0;
    mcast_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", req_o.tvalid, 0);
    chk("reset_out_payload", req_o.t, 0);
    chk("reset_in_ready", rsp_o.tready, 0);
    chk("reset_state", dbg_state, IDLE);
    chk("reset_frames_ok", frames_ok, 0);
    chk("reset_frames_drop", frames_drop, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Own address, 8 beats, output one cycle after each handshake.
    send_frame(MacOwn, 8, 8'hff, 0, 1'b1, 1'b0);
    drain("own_addr");

    // Foreign unicast is swallowed.
    send_frame(MacOther, 5, 8'h0f, 0, 1'b0, 1'b0);
    drain("other_addr");

    // Broadcast and multicast with their enables off, then on.
    send_frame(MacBcast, 3, 8'hff, 0, 1'b0, 1'b0);
    bcast_en = 1'b1;
    send_frame(MacBcast, 3, 8'hff, 0, 1'b1, 1'b0);
    drain("bcast");
    send_frame(MacMcast, 3, 8'h3f, 0, 1'b0, 1'b0);
    mcast_en = 1'b1;
    send_frame(MacMcast, 3, 8'h3f, 0, 1'b1, 1'b0);
    bcast_en = 1'b0;
    mcast_en = 1'b0;
    drain("mcast");

    // Runt dropped even in promiscuous mode.
    promisc = 1'b1;
    send_frame(MacOwn, 1, 8'h0f, 0, 1'b0, 1'b0);
    promisc = 1'b0;
    drain("runt");

    // Downstream toggling, 16 back-to-back matching frames.
    ds_mode = 1;
    for (int f = 0; f < 16; f++) begin
      send_frame(MacOwn, $urandom_range(1, 9), lk_tab[$urandom_range(0, 2)], 0, 1'b0, 1'b0);
    end
    drain("toggle_b2b");

    // Randomized traffic, policy and backpressure; policy changes mid-frame.
    ds_mode = 2;
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 3))
        0:       da = MacOwn;
        1:       da = {$urandom(), 16'($urandom())} & 48'hffff_ffff_fffe;
        2:       da = MacBcast;
        default: da = {$urandom(), 16'($urandom())} | 48'h1;
      endcase
      send_frame(da, $urandom_range(1, 6), lk_tab[$urandom_range(0, 6)],
                 $urandom_range(0, 2), 1'b0, 1'b1);
    end
    promisc  = 1'b0;
    bcast_en = 1'b0;
    mcast_en = 1'b0;
    drain("random");

    // Reset during beat 3 of a 6-beat frame.
    ds_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    for (int k = 0; k < 6; k++) exp_q.push_back(make_beat(MacOwn, k, 6, 8'hff));
    for (int k = 0; k < 3; k++) drive_beat(axis_t'(exp_q[k]), 1'b0);
    req_i.t      = axis_t'(exp_q[exp_q.size() - 3]);
    req_i.tvalid = 1'b1;
    #2;
    rst_ni = 1'b0;
    exp_q.delete();
    exp_ok   = 0;
    exp_drop = 0;
    #1;
    chk("midreset_out_valid", req_o.tvalid, 0);
    chk("midreset_out_payload", req_o.t, 0);
    chk("midreset_in_ready", rsp_o.tready, 0);
    chk("midreset_state", dbg_state, IDLE);
    chk("midreset_frames_ok", frames_ok, 0);
    req_i.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    send_frame(MacOwn, 4, 8'hff, 0, 1'b1, 1'b0);
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
